// File: rtl/ofmap_bit_packer_if.sv
// Bundles the thresholded bit stream, the layer flush handshake and the
// ofmaps BRAM write port between the upstream stage and the packer.
interface ofmap_bit_packer_if #(
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
  parameter int WORD_WIDTH             = 32,
  parameter int WORD_ADDR_WIDTH        = 7
);
  logic                              i_data;
  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] address_in;
  logic                              i_valid;
  logic                              flush;
  logic                              busy;
  logic                              done;
  logic                              bram_wr_en;
  logic [WORD_ADDR_WIDTH-1:0]        bram_wr_addr;
  logic [WORD_WIDTH-1:0]             bram_wr_data;
  logic [WORD_WIDTH-1:0]             bram_wr_mask;
  logic [15:0]                       word_count;

  // master: the upstream producer / layer controller side
  modport master (
    output i_data, address_in, i_valid, flush,
    input  busy, done, bram_wr_en, bram_wr_addr, bram_wr_data, bram_wr_mask, word_count
  );

  // slave: the packer itself
  modport slave (
    input  i_data, address_in, i_valid, flush,
    output busy, done, bram_wr_en, bram_wr_addr, bram_wr_data, bram_wr_mask, word_count
  );
endinterface

// File: rtl/ofmap_bit_packer.sv
// Packs the 1-bit thresholded activation stream into masked BRAM word writes,
// with an end-of-layer drain that writes the final partial word and pulses done.
module ofmap_bit_packer #(
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
  parameter int WORD_WIDTH             = 32,
  parameter int WORD_ADDR_WIDTH        = 7,
  parameter int DRAIN_CYCLES           = 10
) (
  input logic               clk,
  input logic               rst_n,
  ofmap_bit_packer_if.slave bus
);

  localparam int IDX_W = $clog2(WORD_WIDTH);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {ACTIVE, DRAIN, FLUSH_WR, DONE} state_t;

  state_t                     state_reg;
  logic [CNT_W-1:0]           drain_cnt_reg;
  logic [WORD_WIDTH-1:0]      buf_data_reg;
  logic [WORD_WIDTH-1:0]      buf_mask_reg;
  logic [WORD_ADDR_WIDTH-1:0] buf_waddr_reg;
  logic                       buf_valid_reg;

  logic [WORD_ADDR_WIDTH-1:0] in_waddr;
  logic [IDX_W-1:0]           in_idx;
  logic [WORD_WIDTH-1:0]      in_onehot;
  logic                       keep_buf;
  logic [WORD_WIDTH-1:0]      merged_data;
  logic [WORD_WIDTH-1:0]      merged_mask;
  logic                       evict;
  logic                       full;

  logic                       wr_fire;
  logic [WORD_ADDR_WIDTH-1:0] wr_addr_next;
  logic [WORD_WIDTH-1:0]      wr_data_next;
  logic [WORD_WIDTH-1:0]      wr_mask_next;
  logic [WORD_WIDTH-1:0]      buf_data_next;
  logic [WORD_WIDTH-1:0]      buf_mask_next;
  logic [WORD_ADDR_WIDTH-1:0] buf_waddr_next;
  logic                       buf_valid_next;
  logic [CNT_W-1:0]           drain_cnt_inc;

  assign in_waddr = bus.address_in[OFMAPS_BRAM_ADDR_WIDTH-1:IDX_W];
  assign in_idx   = bus.address_in[IDX_W-1:0];

  generate
    for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_onehot
      assign in_onehot[gi] = (in_idx == IDX_W'(gi));
    end
  endgenerate

  // FLUSH_WR always empties the buffer, so an incoming bit there starts a fresh word.
  assign keep_buf    = buf_valid_reg && (in_waddr == buf_waddr_reg) && (state_reg != FLUSH_WR);
  assign merged_mask = (keep_buf ? buf_mask_reg : '0) | in_onehot;
  assign merged_data = ((keep_buf ? buf_data_reg : '0) & ~in_onehot)
                     | (bus.i_data ? in_onehot : '0);
  assign evict       = bus.i_valid && buf_valid_reg && !keep_buf && (state_reg != FLUSH_WR);
  assign full        = bus.i_valid && (&merged_mask);

  assign drain_cnt_inc = drain_cnt_reg + CNT_W'(1);

  always_comb begin
    wr_fire        = 1'b0;
    wr_addr_next   = buf_waddr_reg;
    wr_data_next   = buf_data_reg;
    wr_mask_next   = buf_mask_reg;
    buf_data_next  = buf_data_reg;
    buf_mask_next  = buf_mask_reg;
    buf_waddr_next = buf_waddr_reg;
    buf_valid_next = buf_valid_reg;

    if (state_reg == FLUSH_WR) begin
      wr_fire        = buf_valid_reg;
      buf_valid_next = 1'b0;
    end else if (evict) begin
      wr_fire = 1'b1;
    end else if (full) begin
      wr_fire      = 1'b1;
      wr_addr_next = in_waddr;
      wr_data_next = merged_data;
      wr_mask_next = merged_mask;
    end

    if (bus.i_valid) begin
      buf_data_next  = merged_data;
      buf_mask_next  = merged_mask;
      buf_waddr_next = in_waddr;
      buf_valid_next = !full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ACTIVE;
      drain_cnt_reg    <= '0;
      buf_data_reg     <= '0;
      buf_mask_reg     <= '0;
      buf_waddr_reg    <= '0;
      buf_valid_reg    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.bram_wr_en   <= 1'b0;
      bus.bram_wr_addr <= '0;
      bus.bram_wr_data <= '0;
      bus.bram_wr_mask <= '0;
      bus.word_count   <= '0;
    end else begin
      buf_data_reg   <= buf_data_next;
      buf_mask_reg   <= buf_mask_next;
      buf_waddr_reg  <= buf_waddr_next;
      buf_valid_reg  <= buf_valid_next;
      bus.bram_wr_en <= wr_fire;
      bus.done       <= 1'b0;
      if (wr_fire) begin
        bus.bram_wr_addr <= wr_addr_next;
        bus.bram_wr_data <= wr_data_next;
        bus.bram_wr_mask <= wr_mask_next;
      end

      if (state_reg == DONE) begin
        bus.word_count <= '0;
      end else if (wr_fire && (bus.word_count != 16'hFFFF)) begin
        bus.word_count <= bus.word_count + 16'd1;
      end

      case (state_reg)
        ACTIVE: begin
          if (bus.flush) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= '0;
            bus.busy      <= 1'b1;
          end
        end
        DRAIN: begin
          // Any late bit from the upstream pipeline restarts the idle window.
          if (bus.i_valid) begin
            drain_cnt_reg <= '0;
          end else begin
            drain_cnt_reg <= drain_cnt_inc;
            if (drain_cnt_inc == CNT_W'(DRAIN_CYCLES)) begin
              state_reg <= FLUSH_WR;
            end
          end
        end
        FLUSH_WR: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= ACTIVE;
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_bit_packer.sv
// Directed bench for ofmap_bit_packer: a word-level model is compared with the
// DUT every cycle, plus literal checks on the hand-computed scenarios.
module tb_ofmap_bit_packer;
  localparam int AW  = 12;
  localparam int WW  = 32;
  localparam int WAW = 7;
  localparam int DC  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ofmap_bit_packer_if #(.OFMAPS_BRAM_ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORD_ADDR_WIDTH(WAW)) bus ();

  ofmap_bit_packer #(
    .OFMAPS_BRAM_ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORD_ADDR_WIDTH(WAW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the pending word is a set of (bit index -> value); -1 means unwritten.
  int             mbit[WW];
  int             mword;
  int             mcount;
  int             phase;   // 0 normal, 1 draining, 2 final write due, 3 completion due
  int             idle;
  logic           exp_wr_en;
  logic [WAW-1:0] exp_addr;
  logic [WW-1:0]  exp_data;
  logic [WW-1:0]  exp_mask;
  logic           exp_busy;
  logic           exp_done;
  int             exp_wc;

  function automatic void clear_word();
    for (int i = 0; i < WW; i++) mbit[i] = -1;
    mcount = 0;
  endfunction

  function automatic void model_reset();
    clear_word();
    mword = 0; phase = 0; idle = 0;
    exp_wr_en = 0; exp_addr = '0; exp_data = '0; exp_mask = '0;
    exp_busy = 0; exp_done = 0; exp_wc = 0;
  endfunction

  function automatic void write_word();
    exp_wr_en = 1;
    exp_addr  = mword[WAW-1:0];
    exp_data  = '0;
    exp_mask  = '0;
    for (int i = 0; i < WW; i++) begin
      if (mbit[i] >= 0) exp_mask[i] = 1'b1;
      if (mbit[i] == 1) exp_data[i] = 1'b1;
    end
    if (exp_wc < 65535) exp_wc++;
    clear_word();
  endfunction

  function automatic void put_bit(input int d, input int a);
    int w, idx;
    w   = a / WW;
    idx = a % WW;
    if (mcount > 0 && w != mword) write_word();
    mword = w;
    if (mbit[idx] < 0) mcount++;
    mbit[idx] = d;
    if (mcount == WW) write_word();
  endfunction

  function automatic void model_step();
    int v, d, a, f;
    v = int'(bus.i_valid); d = int'(bus.i_data); a = int'(bus.address_in); f = int'(bus.flush);
    exp_wr_en = 0;
    exp_done  = 0;
    if (phase == 2) begin
      if (mcount > 0) write_word();
      if (v == 1) put_bit(d, a);
      phase = 3;
    end else if (phase == 3) begin
      if (v == 1) put_bit(d, a);
      exp_done = 1; exp_busy = 0; exp_wc = 0;
      phase = 0;
    end else begin
      if (v == 1) put_bit(d, a);
      if (phase == 0 && f == 1) begin
        phase = 1; idle = 0; exp_busy = 1;
      end else if (phase == 1) begin
        idle = (v == 1) ? 0 : idle + 1;
        if (idle == DC) phase = 2;
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_wr_en", bus.bram_wr_en, exp_wr_en);
      if (exp_wr_en) begin
        chk("cyc_wr_addr", bus.bram_wr_addr, exp_addr);
        chk("cyc_wr_data", bus.bram_wr_data, exp_data);
        chk("cyc_wr_mask", bus.bram_wr_mask, exp_mask);
      end
      chk("cyc_busy", bus.busy, exp_busy);
      chk("cyc_done", bus.done, exp_done);
      chk("cyc_word_count", bus.word_count, exp_wc);
    end
  end

  task automatic cyc(input logic v, input logic d, input int a, input logic f);
    bus.i_valid    = v;
    bus.i_data     = d;
    bus.address_in = a[AW-1:0];
    bus.flush      = f;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.flush   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cyc(1'b0, 1'b0, 0, 1'b0);
  endtask

  // Counts edges since the last driven cycle until the final write appears (bounded).
  task automatic wait_write(input string name, input int exp_edges, input logic [WAW-1:0] ea,
                            input logic [WW-1:0] ed, input logic [WW-1:0] em);
    int  k;
    bit  seen;
    seen = 0;
    for (k = 1; k <= 40; k++) begin
      cyc(1'b0, 1'b0, 0, 1'b0);
      if (bus.bram_wr_en) begin
        seen = 1;
        break;
      end
    end
    chk({name, "_latency"}, k, exp_edges);
    if (seen) begin
      chk({name, "_addr"}, bus.bram_wr_addr, ea);
      chk({name, "_data"}, bus.bram_wr_data, ed);
      chk({name, "_mask"}, bus.bram_wr_mask, em);
      chk({name, "_busy_at_wr"}, bus.busy, 1'b1);
      chk({name, "_done_at_wr"}, bus.done, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      chk({name, "_done"}, bus.done, 1'b1);
      chk({name, "_busy_clr"}, bus.busy, 1'b0);
      chk({name, "_wc_clr"}, bus.word_count, 16'd0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      chk({name, "_done_pulse"}, bus.done, 1'b0);
    end
  endtask

  initial begin
    int dn;
    int wn;
    bus.i_valid = 1'b0; bus.i_data = 1'b0; bus.address_in = '0; bus.flush = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", bus.bram_wr_en, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_wc", bus.word_count, 16'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sequential fill of word 0
    for (int a = 0; a < 32; a++) cyc(1'b1, a[0], a, 1'b0);
    chk("fill_wr_en", bus.bram_wr_en, 1'b1);
    chk("fill_addr", bus.bram_wr_addr, 7'd0);
    chk("fill_data", bus.bram_wr_data, 32'hAAAAAAAA);
    chk("fill_mask", bus.bram_wr_mask, 32'hFFFFFFFF);
    chk("fill_wc", bus.word_count, 16'd1);

    // Eviction, then a flush carrying a bit in the same cycle
    cyc(1'b1, 1'b1, 5, 1'b0);
    cyc(1'b1, 1'b1, 40, 1'b0);
    chk("evict_wr_en", bus.bram_wr_en, 1'b1);
    chk("evict_addr", bus.bram_wr_addr, 7'd0);
    chk("evict_data", bus.bram_wr_data, 32'h20);
    chk("evict_mask", bus.bram_wr_mask, 32'h20);
    chk("evict_wc", bus.word_count, 16'd2);
    cyc(1'b1, 1'b1, 41, 1'b1);
    chk("flush_busy", bus.busy, 1'b1);
    wait_write("evict_flush", 11, 7'd1, 32'h300, 32'h300);

    // Flush/drain of a partial word
    cyc(1'b1, 1'b1, 64, 1'b0);
    cyc(1'b1, 1'b0, 65, 1'b0);
    cyc(1'b1, 1'b1, 66, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    wait_write("drain", 11, 7'd2, 32'h5, 32'h7);

    // Late bit on drain idle cycle 5 restarts the idle window; a second flush is ignored
    cyc(1'b0, 1'b0, 0, 1'b1);
    idle_cycles(2);
    cyc(1'b0, 1'b0, 0, 1'b1);
    idle_cycles(1);
    cyc(1'b1, 1'b1, 100, 1'b0);
    wait_write("late", 11, 7'd3, 32'h10, 32'h10);

    // Duplicate index overwrites data, mask unchanged
    cyc(1'b1, 1'b1, 7, 1'b0);
    cyc(1'b1, 1'b0, 7, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    wait_write("dup", 11, 7'd0, 32'h0, 32'h80);

    // Reset during drain with a partial buffer
    cyc(1'b1, 1'b1, 200, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    idle_cycles(3);
    chk("mid_busy_before_rst", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_wr_en", bus.bram_wr_en, 1'b0);
    chk("arst_wr_data", bus.bram_wr_data, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    dn = 0;
    wn = 0;
    repeat (15) begin
      cyc(1'b0, 1'b0, 0, 1'b0);
      if (bus.done) dn++;
      if (bus.bram_wr_en) wn++;
    end
    chk("rst_no_done", dn, 0);
    chk("rst_no_write", wn, 0);
    cyc(1'b1, 1'b1, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    wait_write("fresh", 11, 7'd0, 32'h1, 32'h1);

    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ofmap_bit_packer.md
Name: ofmap_bit_packer

Overview:
- Consumes the 1-bit thresholded activation stream (data, bit address, valid) produced by the popcount/threshold stage.
- Packs the bits into WORD_WIDTH-bit words and issues masked word writes to the ofmaps BRAM.
- Supports a flush/drain sequence at end of layer, so the last partial word is written and completion is signalled to the layer controller.
- Sits between the popcount/threshold pipeline and the ofmaps BRAM write port.

Parameters:
OFMAPS_BRAM_ADDR_WIDTH, 12, width of incoming bit address
WORD_WIDTH, 32, packed BRAM word width (power of two)
WORD_ADDR_WIDTH, 7, BRAM word address width = OFMAPS_BRAM_ADDR_WIDTH - log2(WORD_WIDTH)
DRAIN_CYCLES, 10, idle cycles of i_valid required after flush before final write (matches upstream pipeline depth)

Ports:
clk  in  1  clock
rst_n  in  1  reset
i_data  in  1  thresholded activation bit
address_in  in  OFMAPS_BRAM_ADDR_WIDTH  bit address of i_data
i_valid  in  1  input strobe; no backpressure, one bit accepted per cycle
flush  in  1  single-cycle pulse: end of layer
busy  out  1  high from flush acceptance until done
done  out  1  one-cycle pulse when drain complete
bram_wr_en  out  1  write strobe
bram_wr_addr  out  WORD_ADDR_WIDTH  word address
bram_wr_data  out  WORD_WIDTH  packed data
bram_wr_mask  out  WORD_WIDTH  per-bit write enable (1 = write)
word_count  out  16  words written since last flush completion, saturating

Behaviour:
- Interface: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, buffer empty, state ACTIVE, counters 0.
- Address split: word address = address_in[MSB:log2(WORD_WIDTH)]; bit index = address_in[log2(WORD_WIDTH)-1:0]. Bit index 0 is data LSB.
- Internal state: one word buffer (buf_data, buf_mask, buf_waddr, buf_valid).
- i_valid with buffer empty, or with word address equal to buf_waddr:
  - Set buf_data[idx] = i_data and buf_mask[idx] = 1.
  - A repeated index overwrites the data bit; the mask is unchanged.
- i_valid with a different word address (eviction):
  - At that edge, the current buffer is copied to bram_wr_* with bram_wr_en = 1.
  - The buffer is reloaded holding only the new bit.
- Full word: if the update makes the mask all-ones, the completed word (including the new bit) goes directly to bram_wr_* at that edge and the buffer empties.
- All BRAM outputs are registered. The write is visible the cycle after the causing input. bram_wr_en is high for exactly one cycle per write, and at most one write per cycle.
- Masked bits: data bits with mask = 0 are driven 0.
- FSM:
  - ACTIVE: normal operation. flush -> DRAIN with drain counter = 0 and busy = 1. An i_valid in the same cycle as flush is processed normally first.
  - DRAIN: bits keep being packed and evicted as in ACTIVE. The counter increments on cycles with i_valid = 0 and resets to 0 on any i_valid. When the counter reaches DRAIN_CYCLES -> FLUSH_WR.
  - FLUSH_WR (1 cycle): if buf_valid, write the buffer (partial mask) and empty it; otherwise no write. -> DONE.
  - DONE (1 cycle): done = 1, busy = 0, word_count cleared on the next edge. -> ACTIVE.
- flush while busy: ignored.
- i_valid during FLUSH_WR/DONE: not permitted upstream. If it occurs, the bit is stored into the (now empty) buffer and not lost.
- word_count: increments on every bram_wr_en and saturates at 16'hFFFF.
- Reset asserted mid-operation: buffer contents discarded with no write, FSM back to ACTIVE, done/busy 0 immediately (asynchronous).

Test Plan:
- Sequential fill: 32 bits at addresses 0..31, i_data = address[0], back-to-back → one write, cycle after the 32nd bit: addr 0, data 32'hAAAAAAAA, mask 32'hFFFFFFFF, word_count = 1.
- Eviction: bits addr 5 (1) then addr 40 (1) → after the second bit: write addr 0, data 32'h20, mask 32'h20. Buffer holds word 1, bit 8.
- Flush/drain: bits addr 64..66 = 1,0,1, then flush → no write until 10 idle cycles. Then one write addr 2, data 32'h5, mask 32'h7; done one cycle later; busy high from the flush edge through FLUSH_WR.
- Late bits after flush: flush, then i_valid on drain idle cycle 5 (addr 100) → drain counter restarts. Final write includes bit 4 of word 3; done delayed accordingly.
- Duplicate index: addr 7 = 1 then addr 7 = 0, then flush → final write data 32'h0, mask 32'h80.
- Reset mid-drain: assert rst_n low during DRAIN with a partial buffer → no write, done never pulses, all outputs 0. After release, the first bit at addr 0 starts a fresh word.
